rgb_breath_pwm: RTL and testbench

- Multi-channel PWM LED driver with per-channel modes: off, static duty, breathing (triangle ramp), inverted-phase breathing.
- One shared PWM period counter feeds all channels. Breathing advances only while `run` is high.
- Per-channel config is written through a single-cycle write port and applied glitch-free at the next period boundary.
- Drives the RGB LED channels on the expansion board.

---
 rtl/rgb_pwm_pkg.sv | 17 +
 rtl/pwm_breath_channel.sv | 121 ++++++++++++
 rtl/rgb_breath_pwm.sv | 78 +++++++
 tb/tb_rgb_breath_pwm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB breathing PWM driver.
package rgb_pwm_pkg;

    // Per-channel operating mode as carried on the config write port.
    typedef enum logic [1:0] {
        MODE_OFF         = 2'd0,
        MODE_STATIC      = 2'd1,
        MODE_BREATHE     = 2'd2,
        MODE_BREATHE_INV = 2'd3
    } mode_e;

    // True for either breathing flavour; both ramp the level the same way.
    function automatic logic is_breathe(mode_e mode);
        return (mode == MODE_BREATHE) || (mode == MODE_BREATHE_INV);
    endfunction

endpackage

// File: rtl/pwm_breath_channel.sv
// One PWM channel: shadow/active config, breathing level ramp and output compare.
module pwm_breath_channel
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PwmBits = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  mode_e              mode_i,
    input  logic [PwmBits-1:0] duty_i,
    input  logic               boundary_i,
    input  logic               step_i,
    input  logic [PwmBits-1:0] cnt_i,
    output logic               pwm_o
);

    mode_e              shadow_mode_q, shadow_mode_d;
    logic [PwmBits-1:0] shadow_duty_q, shadow_duty_d;
    logic               pending_q, pending_d;
    mode_e              mode_q, mode_d;
    logic [PwmBits-1:0] duty_q, duty_d;
    logic [PwmBits-1:0] level_q, level_d;
    logic               dir_down_q, dir_down_d;
    logic               pwm_q, pwm_d;
    logic [PwmBits-1:0] eff_duty;

    // Next-state: config apply at the boundary, then the breathing step on the new config.
    always_comb begin
        shadow_mode_d = shadow_mode_q;
        shadow_duty_d = shadow_duty_q;
        pending_d     = pending_q;
        mode_d        = mode_q;
        duty_d        = duty_q;
        level_d       = level_q;
        dir_down_d    = dir_down_q;

        if (boundary_i && pending_q) begin
            pending_d = 1'b0;
            mode_d    = shadow_mode_q;
            duty_d    = shadow_duty_q;
            // A peak-only update keeps the ramp where it is.
            if (shadow_mode_q != mode_q) begin
                if (shadow_mode_q == MODE_BREATHE) begin
                    level_d    = '0;
                    dir_down_d = 1'b0;
                end else if (shadow_mode_q == MODE_BREATHE_INV) begin
                    level_d    = shadow_duty_q;
                    dir_down_d = 1'b1;
                end
            end
        end

        // step_i is only ever high on a boundary cycle.
        if (step_i && is_breathe(mode_d)) begin
            if (!dir_down_d) begin
                if (level_d == duty_d) begin
                    dir_down_d = 1'b1;
                end else if (level_d > duty_d) begin
                    // Peak was lowered below the current level.
                    dir_down_d = 1'b1;
                    level_d    = level_d - 1'b1;
                end else begin
                    level_d = level_d + 1'b1;
                end
            end else begin
                if (level_d == '0) begin
                    dir_down_d = 1'b0;
                end else begin
                    level_d = level_d - 1'b1;
                end
            end
        end

        // A write on the boundary cycle stays pending for the next boundary.
        if (we_i) begin
            shadow_mode_d = mode_i;
            shadow_duty_d = duty_i;
            pending_d     = 1'b1;
        end
    end

    // Effective compare value from the active config and the PWM decision.
    always_comb begin
        eff_duty = '0;
        case (mode_q)
            MODE_OFF:         eff_duty = '0;
            MODE_STATIC:      eff_duty = duty_q;
            MODE_BREATHE,
            MODE_BREATHE_INV: eff_duty = level_q;
            default:          eff_duty = '0;
        endcase
        pwm_d = (cnt_i < eff_duty);
    end

    // Channel state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_mode_q <= MODE_OFF;
            shadow_duty_q <= '0;
            pending_q     <= 1'b0;
            mode_q        <= MODE_OFF;
            duty_q        <= '0;
            level_q       <= '0;
            dir_down_q    <= 1'b0;
            pwm_q         <= 1'b0;
        end else begin
            shadow_mode_q <= shadow_mode_d;
            shadow_duty_q <= shadow_duty_d;
            pending_q     <= pending_d;
            mode_q        <= mode_d;
            duty_q        <= duty_d;
            level_q       <= level_d;
            dir_down_q    <= dir_down_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_breath_pwm.sv
// Multi-channel breathing PWM LED driver with a shared period counter.
module rgb_breath_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned CHANNELS     = 3,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned STEP_PERIODS = 64,
    parameter int unsigned CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                cfg_we,
    input  logic [CH_BITS-1:0]  cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam int unsigned PresBits = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PresBits-1:0] presc_q, presc_d;
    logic                period_start_q, period_start_d;
    logic                boundary;
    logic                step;

    assign boundary = (cnt_q == '1);
    assign step     = boundary && run && (presc_q == PresBits'(STEP_PERIODS - 1));

    // Period counter, breathing prescaler and period-start pulse next-state.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        presc_d = presc_q;
        if (boundary && run) begin
            presc_d = step ? '0 : presc_q + 1'b1;
        end
        // Registered alongside the output flops, so it lines up with the cnt=0 output cycle.
        period_start_d = (cnt_q == '0);
    end

    // Shared timing registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q          <= '0;
            presc_q        <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            presc_q        <= presc_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic ch_we;
        // Out-of-range channel numbers match no instance and are dropped.
        assign ch_we = cfg_we && (cfg_ch == CH_BITS'(i));

        pwm_breath_channel #(
            .PwmBits(PWM_BITS)
        ) u_ch (
            .clk_i     (clk),
            .rst_ni    (reset),
            .we_i      (ch_we),
            .mode_i    (mode_e'(cfg_mode)),
            .duty_i    (cfg_duty),
            .boundary_i(boundary),
            .step_i    (step),
            .cnt_i     (cnt_q),
            .pwm_o     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_rgb_breath_pwm.sv
// Period-by-period directed bench for rgb_breath_pwm (4-bit PWM, 2 periods per step).
module tb_rgb_breath_pwm;

    localparam int NCH = 3;

    logic           clk;
    logic           reset;
    logic           run;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [1:0]     cfg_mode;
    logic [3:0]     cfg_duty;
    logic [NCH-1:0] pwm_out;
    logic           period_start;

    rgb_breath_pwm #(
        .CHANNELS    (3),
        .PWM_BITS    (4),
        .STEP_PERIODS(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_mode    (cfg_mode),
        .cfg_duty    (cfg_duty),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per PWM period: run level, up to two writes, expected high count per channel.
    typedef struct {
        logic       run;
        int         a_it;
        logic [1:0] a_ch;
        logic [1:0] a_md;
        logic [3:0] a_dt;
        int         b_it;
        logic [1:0] b_ch;
        logic [1:0] b_md;
        logic [3:0] b_dt;
        int         e0;
        int         e1;
        int         e2;
    } vec_t;

    vec_t vecs[$];

    int n_vec  = 0;
    int n_miss = 0;

    // ch1 BREATHE peak 3 and ch2 BREATHE_INV peak 6 over the 21 running periods.
    int exp_b1[21] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 2, 2, 1, 1, 0, 0, 0, 0, 1, 1, 2};
    int exp_b2[21] = '{6, 6, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0, 0, 0, 1, 1, 2, 2, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r,
                                input int a_it, input logic [1:0] a_ch, input logic [1:0] a_md,
                                input logic [3:0] a_dt,
                                input int b_it, input logic [1:0] b_ch, input logic [1:0] b_md,
                                input logic [3:0] b_dt,
                                input int e0, input int e1, input int e2);
        vec_t v;
        v.run = r;
        v.a_it = a_it; v.a_ch = a_ch; v.a_md = a_md; v.a_dt = a_dt;
        v.b_it = b_it; v.b_ch = b_ch; v.b_md = b_md; v.b_dt = b_dt;
        v.e0 = e0; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    // Plain period: no writes.
    function automatic vec_t mkp(input logic r, input int e0, input int e1, input int e2);
        return mk(r, -1, 2'd0, 2'd0, 4'd0, -1, 2'd0, 2'd0, 4'd0, e0, e1, e2);
    endfunction

    // Period with a single write.
    function automatic vec_t mkw(input logic r, input int it, input logic [1:0] ch,
                                 input logic [1:0] md, input logic [3:0] dt,
                                 input int e0, input int e1, input int e2);
        return mk(r, it, ch, md, dt, -1, 2'd0, 2'd0, 4'd0, e0, e1, e2);
    endfunction

    // Entered at the negedge where period_start is high; leaves at the next such negedge.
    // Iteration it samples the output for cnt=it; a write driven there lands at cnt=it+1.
    task automatic run_period(input vec_t v, input string tag);
        logic [15:0] pat[NCH];
        logic [15:0] ps_pat;
        int          e[NCH];
        logic [15:0] mask;
        e[0] = v.e0;
        e[1] = v.e1;
        e[2] = v.e2;
        for (int c = 0; c < NCH; c++) pat[c] = '0;
        ps_pat = '0;
        for (int it = 0; it < 16; it++) begin
            run    = v.run;
            cfg_we = 1'b0;
            if (v.a_it == it) begin
                cfg_we = 1'b1; cfg_ch = v.a_ch; cfg_mode = v.a_md; cfg_duty = v.a_dt;
            end
            if (v.b_it == it) begin
                cfg_we = 1'b1; cfg_ch = v.b_ch; cfg_mode = v.b_md; cfg_duty = v.b_dt;
            end
            for (int c = 0; c < NCH; c++) pat[c][it] = pwm_out[c];
            ps_pat[it] = period_start;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            mask = 16'((32'd1 << e[c]) - 32'd1);
            check($sformatf("%s pwm_out[%0d] pattern", tag, c), 32'(pat[c]), 32'(mask));
        end
        check($sformatf("%s period_start pattern", tag), 32'(ps_pat), 32'h0001);
    endtask

    // Bounded wait for period_start; exp_n is the required number of negedges.
    task automatic wait_ps(input int exp_n, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 40);
        check($sformatf("%s period_start seen", tag), 32'(period_start), 32'd1);
        check($sformatf("%s period_start delay", tag), n, exp_n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        run      = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_mode = '0;
        cfg_duty = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset pwm_out", 32'(pwm_out), 32'd0);
        check("reset period_start", 32'(period_start), 32'd0);
        reset = 1'b1;
        wait_ps(1, "first release");

        // ch0 STATIC 8, then pull reset low mid-period.
        run_period(mkw(1'b0, 3, 2'd0, 2'd1, 4'd8, 0, 0, 0), "pre-reset write");
        run_period(mkp(1'b0, 8, 0, 0), "pre-reset static8");
        @(negedge clk);
        @(negedge clk);
        check("mid-period high before reset", 32'(pwm_out[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async reset pwm_out", 32'(pwm_out), 32'd0);
        check("async reset period_start", 32'(period_start), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("held reset pwm_out", 32'(pwm_out), 32'd0);
        reset = 1'b1;
        wait_ps(1, "second release");
        run_period(mkp(1'b0, 0, 0, 0), "post-reset p0");
        run_period(mkp(1'b0, 0, 0, 0), "post-reset p1");

        // Directed period table.
        vecs.push_back(mkw(1'b0, 3, 2'd0, 2'd1, 4'd5, 0, 0, 0));
        vecs.push_back(mkp(1'b0, 5, 0, 0));
        vecs.push_back(mkw(1'b0, 3, 2'd0, 2'd1, 4'd0, 5, 0, 0));
        vecs.push_back(mkp(1'b0, 0, 0, 0));
        vecs.push_back(mkw(1'b0, 3, 2'd0, 2'd1, 4'd15, 0, 0, 0));
        vecs.push_back(mkp(1'b0, 15, 0, 0));
        vecs.push_back(mkw(1'b0, 3, 2'd0, 2'd1, 4'd10, 15, 0, 0));
        vecs.push_back(mkp(1'b0, 10, 0, 0));
        // Write landing at cnt=7: current period keeps 10.
        vecs.push_back(mkw(1'b0, 6, 2'd0, 2'd1, 4'd3, 10, 0, 0));
        vecs.push_back(mkp(1'b0, 3, 0, 0));
        // Write landing on the boundary cycle (cnt=15): one extra period of delay.
        vecs.push_back(mkw(1'b0, 14, 2'd0, 2'd1, 4'd12, 3, 0, 0));
        vecs.push_back(mkp(1'b0, 3, 0, 0));
        vecs.push_back(mkp(1'b0, 12, 0, 0));
        // Out-of-range channel.
        vecs.push_back(mkw(1'b0, 3, 2'd3, 2'd1, 4'd9, 12, 0, 0));
        vecs.push_back(mkp(1'b0, 12, 0, 0));
        // Two writes to ch2 in one period: last wins.
        vecs.push_back(mk(1'b0, 2, 2'd2, 2'd1, 4'd4, 9, 2'd2, 2'd3, 4'd6, 12, 0, 0));
        vecs.push_back(mkw(1'b0, 3, 2'd1, 2'd2, 4'd3, 12, 0, 6));
        // Breathing with run high.
        for (int i = 0; i < 21; i++) vecs.push_back(mkp(1'b1, 12, exp_b1[i], exp_b2[i]));
        // Frozen for 10 periods.
        for (int i = 0; i < 10; i++) vecs.push_back(mkp(1'b0, 12, 2, 3));
        // Resume: prescaler was mid-count, so the next boundary steps.
        vecs.push_back(mkp(1'b1, 12, 2, 3));
        vecs.push_back(mkp(1'b1, 12, 3, 4));
        vecs.push_back(mkp(1'b1, 12, 3, 4));
        vecs.push_back(mkp(1'b1, 12, 3, 5));

        foreach (vecs[r]) run_period(vecs[r], $sformatf("row%0d", r));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
